elbeth_fetch_unit: RTL and testbench
====================================

# elbeth_fetch_unit

Instruction-fetch initiator for the ELBETH core: drives the read port of `elbeth_memory` (`ctrl_read_e`, `pc_addr`) and collects the returned `instruction` words. It presents them to the decode stage through a valid/ready handshake, buffering up to two words. It also handles PC redirects from the branch logic and faults fetches at or above `` `LIMIT_INSTRUC`` before they reach memory.

## Interface
- `AW`, 32, address width; the PC is a word address.
- `DW`, 32, instruction width.
- `RESET_PC`, 32'h00000000, PC loaded on reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_read_e`  out  1  to memory `ctrl_read_e`.
- `mem_addr`  out  AW  to memory `pc_addr`.
- `mem_data`  in  DW  from memory `instruction`; valid the cycle after a read is issued.
- `redirect_valid`  in  1  load a new PC this cycle.
- `redirect_pc`  in  AW  new PC.
- `out_valid`  out  1  buffered instruction available.
- `out_ready`  in  1  decode accepts the instruction.
- `out_instr`  out  DW  head instruction.
- `out_pc`  out  AW  address of `out_instr`.
- `fault`  out  1  fetch-limit fault; sticky until redirect or reset.
- `fault_pc`  out  AW  offending PC.

## Operation
- **State machine:** `RUN`, `FAULT`. Reset enters `RUN`.
- **Issue condition:** `mem_read_e = RUN && !redirect_valid && pc < LIMIT_INSTRUC && (count + inflight - pop) < 2`.
  - `pop = out_valid && out_ready`.
  - `count` is the number of buffer entries (0..2).
  - `inflight` is 1 if a read was issued in the previous cycle.
- `mem_addr = pc` at all times.
- **On issue:** `pc <= pc + 1` (mod 2^AW), `inflight <= 1`, and the issued PC is recorded for tagging.
- **Capture:** if `inflight && !redirect_valid`, then `{mem_data, tagged pc}` is pushed into the buffer at the end of the cycle.
- **Limit check:** in `RUN`, when `pc >= LIMIT_INSTRUC`, no read is issued.
  - Once `count == 0 && inflight == 0`, go to `FAULT` with `fault_pc <= pc`.
  - In `FAULT`: `fault = 1` and no reads are issued.
- **Redirect (any state):**
  - `pc <= redirect_pc`.
  - Buffer cleared and `inflight <= 0`; the response arriving this cycle is discarded.
  - `fault <= 0`, state goes to `RUN`.
  - No read is issued in the redirect cycle.
  - A pop in the same cycle still counts as accepted by decode.
- **Buffer:** 2-entry FIFO. Simultaneous push and pop is allowed when `count == 2`. Pushing when full cannot occur under the issue rule; assertion-checked.
- **Write port:** the memory's write port is not driven by this block.

## Timing
- **Reset values:** `mem_read_e = 0` (combinational, forced 0 while `rst == 0`), `out_valid = 0`, `out_instr = 0`, `out_pc = 0`, `fault = 0`, `fault_pc = 0`, `pc = RESET_PC`, `count = 0`, `inflight = 0`.
- **Latency:** issue in cycle t, memory registers at end of t, `mem_data` valid in t+1, buffer push at end of t+1, `out_valid` in t+2.
- **First fetch:** `mem_read_e = 1` in the first cycle after reset deasserts.
- **Throughput:** one instruction per cycle with `out_ready` held high.
- **Redirect:** redirect in cycle t gives first issue of `redirect_pc` in t+1 and `out_valid` in t+3.
- **Combinational paths:** `mem_read_e` depends combinationally on `out_ready` and `redirect_valid`. `out_*` are registered outputs of the buffer head.
- **Reset mid-operation:** all state clears immediately; any in-flight memory response is ignored.
- **Held inputs:** `out_instr` and `out_pc` are held stable while `out_valid && !out_ready`.

## Structure
- **Shared definitions:** `` `LIMIT_INSTRUC`` comes from `elbeth_definitions.v`. Add the `RUN`/`FAULT` state encodings (`` `FETCH_RUN``, `` `FETCH_FAULT``) there.
- **Sub-module:** `elbeth_fetch_buf`, a 2-entry FIFO with ports `push`, `pop`, `din{instr,pc}`, `dout`, `count`. It takes the same `clk`/`rst` as the top.

## Test plan
- **Reset and sequential fetch:** memory preloaded with word[k] = 32'hA000_0000 + k; release reset, `out_ready = 1`.
  - Expect `mem_read_e = 1` with `mem_addr = 0` in cycle 1.
  - Expect `out_valid` in cycle 3 with `out_pc` = 0, 1, 2, … and `out_instr` = A000_0000, A000_0001, … on consecutive cycles.
- **Backpressure:** drop `out_ready` for 4 cycles mid-stream.
  - `count` saturates at 2 and `mem_read_e` goes low.
  - `out_instr` stays stable.
  - On release, no word is lost or duplicated; the sequence continues contiguous.
- **Redirect with response in flight:** `redirect_valid` with `redirect_pc = 32'h40` in the cycle a response for pc 5 arrives.
  - The word for pc 5 is never output.
  - Next issued address is 0x40, and the next `out_pc` is 0x40, three cycles later.
- **Limit fault:** `RESET_PC = LIMIT_INSTRUC - 2`.
  - Exactly two instructions are delivered.
  - `mem_read_e` is never high with `mem_addr >= LIMIT_INSTRUC`.
  - `fault = 1` with `fault_pc = LIMIT_INSTRUC` once drained.
  - A subsequent redirect to 0 clears `fault` and fetch resumes.
- **Simultaneous pop, push and issue at `count == 2`:** verify no overflow and that ordering is preserved.
- **Asynchronous reset mid-stream:** assert `rst = 0` between clock edges.
  - `out_valid`, `mem_read_e` and `fault` drop immediately.
  - After release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/elbeth_fetch_unit_pkg.sv
// Shared fetch definitions: instruction-space limit, fetch FSM encodings and
// the buffer-occupancy helper used by the issue rule.
`ifndef ELBETH_DEFINITIONS_FETCH
`define ELBETH_DEFINITIONS_FETCH
`ifndef LIMIT_INSTRUC
`define LIMIT_INSTRUC 32'd256
`endif
`define FETCH_RUN   1'b0
`define FETCH_FAULT 1'b1
`endif

package elbeth_fetch_unit_pkg;

    localparam logic [31:0] LIMIT_PC = `LIMIT_INSTRUC;

    typedef enum logic {
        ST_RUN   = `FETCH_RUN,
        ST_FAULT = `FETCH_FAULT
    } fetch_state_e;

    // Words already buffered plus the one in flight, less the one leaving,
    // must leave room for the response of a new read.
    function automatic logic room_for_issue(input logic [1:0] count,
                                            input logic       inflight,
                                            input logic       pop);
        logic [2:0] occ;
        occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        return occ < 3'd2;
    endfunction

endpackage

// File: rtl/elbeth_fetch_buf.sv
// Two-entry FIFO holding {instr, pc} pairs between memory and decode; the
// head entry is a register so the outputs are glitch-free.
module elbeth_fetch_buf #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);
    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_count;
    logic         w_pop;
    logic         w_push;

    assign w_pop  = pop && (r_count != 2'd0);
    assign w_push = push && (w_pop || (r_count != 2'd2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else if (flush) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= din;
                    else                 r_tail <= din;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= din;
                    end else begin
                        r_head <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && (r_count == 2'd2)));

    assign dout  = r_head;
    assign count = r_count;

endmodule

// File: rtl/elbeth_fetch_unit.sv
// Instruction-fetch initiator: issues reads to elbeth_memory, tags and buffers
// the returned words, handles redirects and faults fetches past the limit.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  ST_RUN   | fetching; stops issuing at the limit and waits for drain
//  ST_FAULT | pc reached the limit with nothing pending; fault held high
module elbeth_fetch_unit
    import elbeth_fetch_unit_pkg::*;
#(
    parameter int          AW       = 32,
    parameter int          DW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          mem_read_e,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_instr,
    output logic [AW-1:0] out_pc,
    output logic          fault,
    output logic [AW-1:0] fault_pc
);
    fetch_state_e     r_state;
    logic [AW-1:0]    r_pc;
    logic [AW-1:0]    r_tag_pc;
    logic             r_inflight;
    logic             r_fault;
    logic [AW-1:0]    r_fault_pc;

    logic             w_pop;
    logic             w_push;
    logic             w_issue;
    logic             w_at_limit;
    logic [1:0]       w_count;
    logic [DW+AW-1:0] w_dout;

    assign w_at_limit = (r_pc >= AW'(LIMIT_PC));
    assign w_pop      = out_valid && out_ready;
    assign w_push     = r_inflight && !redirect_valid;
    assign w_issue    = rst && (r_state == ST_RUN) && !redirect_valid && !w_at_limit
                        && room_for_issue(w_count, r_inflight, w_pop);

    elbeth_fetch_buf #(.W(DW + AW)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (redirect_valid),
        .din   ({mem_data, r_tag_pc}),
        .dout  (w_dout),
        .count (w_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_tag_pc   <= '0;
            r_inflight <= 1'b0;
            r_fault    <= 1'b0;
            r_fault_pc <= '0;
        end else if (redirect_valid) begin
            r_state    <= ST_RUN;
            r_pc       <= redirect_pc;
            r_inflight <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc     <= r_pc + AW'(1);
                r_tag_pc <= r_pc;
            end
            case (r_state)
                ST_RUN: begin
                    if (w_at_limit && (w_count == 2'd0) && !r_inflight) begin
                        r_state    <= ST_FAULT;
                        r_fault    <= 1'b1;
                        r_fault_pc <= r_pc;
                    end
                end
                ST_FAULT: r_fault <= 1'b1;
                default:  r_state <= ST_RUN;
            endcase
        end
    end

    assign mem_read_e = w_issue;
    assign mem_addr   = r_pc;
    assign out_valid  = (w_count != 2'd0);
    assign out_instr  = w_dout[DW+AW-1:AW];
    assign out_pc     = w_dout[AW-1:0];
    assign fault      = r_fault;
    assign fault_pc   = r_fault_pc;

endmodule

// File: tb/tb_elbeth_fetch_unit.sv
// Directed bench for elbeth_fetch_unit: per-cycle vector table for streaming,
// backpressure and redirect, plus sequences for async reset and limit fault.
module tb_elbeth_fetch_unit;
    import elbeth_fetch_unit_pkg::*;

    typedef struct {
        logic        rst_before;
        logic        ready;
        logic        rv;
        logic [31:0] rpc;
        logic        er;
        logic [31:0] ea;
        logic        ev;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        out_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] mem_data = '0;
    logic        mem_read_e;
    logic [31:0] mem_addr;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fault_pc;

    logic        rst_l = 1'b0;
    logic        out_ready_l = 1'b0;
    logic        redirect_valid_l = 1'b0;
    logic [31:0] redirect_pc_l = '0;
    logic [31:0] mem_data_l = '0;
    logic        mem_read_e_l;
    logic [31:0] mem_addr_l;
    logic        out_valid_l;
    logic [31:0] out_instr_l;
    logic [31:0] out_pc_l;
    logic        fault_l;
    logic [31:0] fault_pc_l;

    always #5 clk = ~clk;

    elbeth_fetch_unit #(.AW(32), .DW(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .mem_read_e(mem_read_e), .mem_addr(mem_addr),
        .mem_data(mem_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .fault(fault), .fault_pc(fault_pc)
    );

    elbeth_fetch_unit #(.AW(32), .DW(32), .RESET_PC(LIMIT_PC - 32'd2)) dut_l (
        .clk(clk), .rst(rst_l), .mem_read_e(mem_read_e_l), .mem_addr(mem_addr_l),
        .mem_data(mem_data_l), .redirect_valid(redirect_valid_l), .redirect_pc(redirect_pc_l),
        .out_valid(out_valid_l), .out_ready(out_ready_l), .out_instr(out_instr_l),
        .out_pc(out_pc_l), .fault(fault_l), .fault_pc(fault_pc_l)
    );

    // Memory models: word[k] = A000_0000 + k, registered one cycle after the read.
    always @(posedge clk) if (mem_read_e)   mem_data   <= 32'hA000_0000 + mem_addr;
    always @(posedge clk) if (mem_read_e_l) mem_data_l <= 32'hA000_0000 + mem_addr_l;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rb, input logic ready, input logic rv, input logic [31:0] rpc,
                       input logic er, input logic [31:0] ea, input logic ev, input logic [31:0] epc);
        vec_t v;
        v.rst_before = rb; v.ready = ready; v.rv = rv; v.rpc = rpc;
        v.er = er; v.ea = ea; v.ev = ev; v.epc = epc;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int viol;
        // Sequential fetch, then 4-cycle backpressure (cycles 6..9), then resume.
        add(1, 1, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 1, 1, 0, 0);
        add(0, 1, 0, 0, 1, 2, 1, 0);
        add(0, 1, 0, 0, 1, 3, 1, 1);
        add(0, 1, 0, 0, 1, 4, 1, 2);
        for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 0, 5, 1, 3);
        add(0, 1, 0, 0, 1, 5, 1, 3);
        add(0, 1, 0, 0, 1, 6, 1, 4);
        add(0, 1, 0, 0, 1, 7, 1, 5);
        add(0, 1, 0, 0, 1, 8, 1, 6);
        add(0, 1, 0, 0, 1, 9, 1, 7);
        // Fresh run, redirect to 0x40 while the pc 5 response is on mem_data.
        add(1, 1, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 1, 1, 0, 0);
        add(0, 1, 0, 0, 1, 2, 1, 0);
        add(0, 1, 0, 0, 1, 3, 1, 1);
        add(0, 1, 0, 0, 1, 4, 1, 2);
        add(0, 1, 0, 0, 1, 5, 1, 3);
        add(0, 1, 1, 32'h40, 0, 6, 1, 4);
        add(0, 1, 0, 0, 1, 32'h40, 0, 0);
        add(0, 1, 0, 0, 1, 32'h41, 0, 0);
        add(0, 1, 0, 0, 1, 32'h42, 1, 32'h40);
        add(0, 1, 0, 0, 1, 32'h43, 1, 32'h41);

        @(negedge clk); @(negedge clk); #1;
        check("rst_read_e", 32'(mem_read_e), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_instr", out_instr, 0);
        check("rst_pc", out_pc, 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_fault_pc", fault_pc, 0);
        check("rst_l_read_e", 32'(mem_read_e_l), 0);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) begin
                rst = 1'b0;
                @(negedge clk); @(negedge clk);
                rst = 1'b1;
            end
            out_ready = vecs[i].ready;
            redirect_valid = vecs[i].rv;
            redirect_pc = vecs[i].rpc;
            #1;
            check($sformatf("v%0d_read_e", i), 32'(mem_read_e), 32'(vecs[i].er));
            check($sformatf("v%0d_addr", i), mem_addr, vecs[i].ea);
            check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            check($sformatf("v%0d_fault", i), 32'(fault), 0);
            if (vecs[i].ev) begin
                check($sformatf("v%0d_pc", i), out_pc, vecs[i].epc);
                check($sformatf("v%0d_instr", i), out_instr, 32'hA000_0000 + vecs[i].epc);
            end
            @(negedge clk);
        end
        out_ready = 1'b1; redirect_valid = 1'b0;

        // Asynchronous reset between edges while streaming.
        #2 rst = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 0);
        check("arst_read_e", 32'(mem_read_e), 0);
        check("arst_fault", 32'(fault), 0);
        @(negedge clk) rst = 1'b1;
        #1;
        check("arst_rel_read_e", 32'(mem_read_e), 1);
        check("arst_rel_addr", mem_addr, 0);
        check("arst_rel_valid", 32'(out_valid), 0);
        @(negedge clk); @(negedge clk); #1;
        check("arst_first_valid", 32'(out_valid), 1);
        check("arst_first_pc", out_pc, 0);
        check("arst_first_instr", out_instr, 32'hA000_0000);

        // Limit fault on the second instance, starting at LIMIT-2.
        out_ready_l = 1'b1;
        @(negedge clk) rst_l = 1'b1;
        n = 0; viol = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (mem_read_e_l && (mem_addr_l >= LIMIT_PC)) viol++;
            if (out_valid_l) begin
                check($sformatf("lim_pc%0d", n), out_pc_l, LIMIT_PC - 32'd2 + 32'(n));
                check($sformatf("lim_instr%0d", n), out_instr_l, 32'hA000_0000 + LIMIT_PC - 32'd2 + 32'(n));
                n++;
            end
            @(negedge clk);
        end
        #1;
        check("lim_delivered", 32'(n), 2);
        check("lim_no_read_past", 32'(viol), 0);
        check("lim_fault", 32'(fault_l), 1);
        check("lim_fault_pc", fault_pc_l, LIMIT_PC);
        check("lim_read_e_idle", 32'(mem_read_e_l), 0);
        redirect_valid_l = 1'b1; redirect_pc_l = 32'h0;
        #1;
        check("lim_redir_no_issue", 32'(mem_read_e_l), 0);
        @(negedge clk) redirect_valid_l = 1'b0;
        #1;
        check("lim_redir_fault_clr", 32'(fault_l), 0);
        check("lim_redir_read_e", 32'(mem_read_e_l), 1);
        check("lim_redir_addr", mem_addr_l, 0);
        @(negedge clk); @(negedge clk); #1;
        check("lim_resume_valid", 32'(out_valid_l), 1);
        check("lim_resume_pc", out_pc_l, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
